// File: rtl/alut_inval_logger16.sv
// Logs isolated aged-entry invalidations from the ALUT age checker into a
// show-ahead FIFO drained by APB, with sticky overflow and a saturating drop count.
module alut_inval_logger16 #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int CNT_W = 4
) (
  input  logic             pclk16,
  input  logic             n_p_reset16,
  input  logic             mem_write_age16,
  input  logic [7:0]       mem_addr_age16,
  input  logic [47:0]      lst_inv_addr_cmd16,
  input  logic [1:0]       lst_inv_port_cmd16,
  input  logic [31:0]      curr_time16,
  input  logic             log_pop16,
  input  logic             log_clr16,
  output logic             log_valid16,
  output logic [47:0]      log_addr16,
  output logic [1:0]       log_port16,
  output logic [7:0]       log_index16,
  output logic [31:0]      log_time16,
  output logic [CNT_W-1:0] log_count16,
  output logic             log_overflow16,
  output logic [7:0]       drop_cnt16
);

  localparam int ENT_W = 48 + 2 + 8 + 32;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic              wr_d1_r;
  logic              wr_d2_r;
  logic [7:0]        idx_d1_r;
  logic [ENT_W-1:0]  mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              ovf_r;
  logic [7:0]        drop_r;

  logic              evt_s;
  logic              empty_s;
  logic              full_s;
  logic              pop_ok_s;
  logic              push_s;
  logic              drop_s;
  logic [ENT_W-1:0]  head_s;
  logic [ENT_W-1:0]  entry_s;

  // Event qualification and FIFO control decode
  always_comb begin
    evt_s    = wr_d1_r & ~wr_d2_r & ~mem_write_age16;
    empty_s  = (count_r == {CNT_W{1'b0}});
    full_s   = (count_r == FULL_CNT);
    pop_ok_s = log_pop16 & ~empty_s;
    push_s   = evt_s & (~full_s | pop_ok_s);
    drop_s   = evt_s & full_s & ~pop_ok_s;
    entry_s  = {lst_inv_addr_cmd16, lst_inv_port_cmd16, idx_d1_r, curr_time16};
    head_s   = mem_r[rd_ptr_r];
  end

  // Write-strobe history: only a lone one-cycle strobe marks an aged invalidation
  always_ff @(posedge pclk16 or negedge n_p_reset16) begin
    if (!n_p_reset16) begin
      wr_d1_r  <= 1'b0;
      wr_d2_r  <= 1'b0;
      idx_d1_r <= 8'h00;
    end else begin
      wr_d1_r  <= mem_write_age16;
      wr_d2_r  <= wr_d1_r;
      idx_d1_r <= mem_addr_age16;
    end
  end

  // Log storage; clear wins over a coincident push so the slot is never written
  always_ff @(posedge pclk16 or negedge n_p_reset16) begin
    if (!n_p_reset16) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {ENT_W{1'b0}};
      end
    end else if (push_s && !log_clr16) begin
      mem_r[wr_ptr_r] <= entry_s;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers, occupancy and drop bookkeeping
  always_ff @(posedge pclk16 or negedge n_p_reset16) begin
    if (!n_p_reset16) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      ovf_r    <= 1'b0;
      drop_r   <= 8'h00;
    end else if (log_clr16) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      ovf_r    <= 1'b0;
      drop_r   <= 8'h00;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        ovf_r <= 1'b1;
        if (drop_r != 8'hFF) begin
          drop_r <= drop_r + 8'd1;
        end else begin
          drop_r <= drop_r;
        end
      end else begin
        ovf_r  <= ovf_r;
        drop_r <= drop_r;
      end
    end
  end

  // Head fields read zero whenever the log is empty
  always_comb begin
    log_valid16    = ~empty_s;
    log_count16    = count_r;
    log_overflow16 = ovf_r;
    drop_cnt16     = drop_r;
    if (empty_s) begin
      log_addr16  = 48'h0;
      log_port16  = 2'b00;
      log_index16 = 8'h00;
      log_time16  = 32'h0;
    end else begin
      log_addr16  = head_s[ENT_W-1 -: 48];
      log_port16  = head_s[41:40];
      log_index16 = head_s[39:32];
      log_time16  = head_s[31:0];
    end
  end

endmodule

// File: tb/tb_alut_inval_logger16.sv
// Directed, table-driven bench for alut_inval_logger16 with hand sequences
// for the long sweep, drop-count saturation and reset-after-pulse cases.
module tb_alut_inval_logger16;

  logic        pclk16 = 1'b0;
  logic        n_p_reset16;
  logic        mem_write_age16;
  logic [7:0]  mem_addr_age16;
  logic [47:0] lst_inv_addr_cmd16;
  logic [1:0]  lst_inv_port_cmd16;
  logic [31:0] curr_time16;
  logic        log_pop16;
  logic        log_clr16;
  logic        log_valid16;
  logic [47:0] log_addr16;
  logic [1:0]  log_port16;
  logic [7:0]  log_index16;
  logic [31:0] log_time16;
  logic [3:0]  log_count16;
  logic        log_overflow16;
  logic [7:0]  drop_cnt16;

  always #5 pclk16 = ~pclk16;

  alut_inval_logger16 #(.DEPTH(8), .PTR_W(3), .CNT_W(4)) dut (
    .pclk16(pclk16), .n_p_reset16(n_p_reset16),
    .mem_write_age16(mem_write_age16), .mem_addr_age16(mem_addr_age16),
    .lst_inv_addr_cmd16(lst_inv_addr_cmd16), .lst_inv_port_cmd16(lst_inv_port_cmd16),
    .curr_time16(curr_time16), .log_pop16(log_pop16), .log_clr16(log_clr16),
    .log_valid16(log_valid16), .log_addr16(log_addr16), .log_port16(log_port16),
    .log_index16(log_index16), .log_time16(log_time16), .log_count16(log_count16),
    .log_overflow16(log_overflow16), .drop_cnt16(drop_cnt16)
  );

  typedef struct {
    logic       wr;
    int         ev;   // event whose data drives the inputs, -1 = idle data
    logic       pop;
    logic       clr;
    logic [3:0] cnt;
    logic       ovf;
    logic [7:0] drop;
    int         hk;   // event expected at the head, -1 = empty
  } vec_t;

  vec_t        tbl[$];
  logic [47:0] e_iaddr [0:15];
  logic [1:0]  e_port  [0:15];
  logic [7:0]  e_idx   [0:15];
  logic [31:0] e_tm    [0:15];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic wr, input int ev, input logic pop, input logic clr,
                     input logic [3:0] cnt, input logic ovf, input logic [7:0] drop, input int hk);
    vec_t v;
    v.wr = wr; v.ev = ev; v.pop = pop; v.clr = clr;
    v.cnt = cnt; v.ovf = ovf; v.drop = drop; v.hk = hk;
    tbl.push_back(v);
  endtask

  task automatic drive_idle();
    mem_write_age16 = 1'b0; mem_addr_age16 = 8'h00; lst_inv_addr_cmd16 = 48'h0;
    lst_inv_port_cmd16 = 2'b00; curr_time16 = 32'hDEAD_0000; log_pop16 = 1'b0; log_clr16 = 1'b0;
  endtask

  task automatic tick();
    @(posedge pclk16);
    #1;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, " valid"}, 64'(log_valid16), 64'h0);
    chk({tag, " count"}, 64'(log_count16), 64'h0);
    chk({tag, " overflow"}, 64'(log_overflow16), 64'h0);
    chk({tag, " drop"}, 64'(drop_cnt16), 64'h0);
    chk({tag, " head"}, {8'h00, log_addr16, log_port16, log_index16[5:0]}, 64'h0);
    chk({tag, " index"}, 64'(log_index16), 64'h0);
    chk({tag, " time"}, 64'(log_time16), 64'h0);
  endtask

  initial begin
    n_p_reset16 = 1'b0;
    drive_idle();
    e_iaddr[0] = 48'h0011_2233_4455; e_port[0] = 2'b10; e_idx[0] = 8'h05; e_tm[0] = 32'h0000_0100;
    for (int k = 1; k < 16; k++) begin
      e_iaddr[k] = 48'hA0B0_C0D0_0000 + 48'(k);
      e_port[k]  = 2'(k);
      e_idx[k]   = 8'h20 + 8'(k);
      e_tm[k]    = 32'h0000_1000 + 32'(k * 16);
    end

    // single pulse, show-ahead hold, pop, pop-on-empty, 2-cycle run
    add(1'b0, -1, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0, -1);
    add(1'b1,  0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0, -1);
    add(1'b0,  0, 1'b0, 1'b0, 4'd1, 1'b0, 8'd0,  0);
    add(1'b0, -1, 1'b0, 1'b0, 4'd1, 1'b0, 8'd0,  0);
    add(1'b0, -1, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0, -1);
    add(1'b0, -1, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0, -1);
    add(1'b1,  3, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0, -1);
    add(1'b1,  3, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0, -1);
    add(1'b0,  3, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0, -1);
    add(1'b0, -1, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0, -1);
    // ten isolated pulses into an 8-deep log
    for (int j = 0; j < 10; j++) begin
      add(1'b1, j + 1, 1'b0, 1'b0, 4'((j > 8) ? 8 : j), 1'(j > 8),
          8'((j > 8) ? j - 8 : 0), (j == 0) ? -1 : 1);
      add(1'b0, j + 1, 1'b0, 1'b0, 4'((j + 1 > 8) ? 8 : j + 1), 1'(j + 1 > 8),
          8'((j + 1 > 8) ? j + 1 - 8 : 0), 1);
    end
    // push and pop together while full, then drain two
    add(1'b1, 11, 1'b0, 1'b0, 4'd8, 1'b1, 8'd2, 1);
    add(1'b0, 11, 1'b1, 1'b0, 4'd8, 1'b1, 8'd2, 2);
    add(1'b0, -1, 1'b1, 1'b0, 4'd7, 1'b1, 8'd2, 3);
    add(1'b0, -1, 1'b1, 1'b0, 4'd6, 1'b1, 8'd2, 4);
    add(1'b0, -1, 1'b0, 1'b1, 4'd0, 1'b0, 8'd0, -1);
    // three entries, then clear coincident with an event
    add(1'b1, 12, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0, -1);
    add(1'b0, 12, 1'b0, 1'b0, 4'd1, 1'b0, 8'd0, 12);
    add(1'b1, 13, 1'b0, 1'b0, 4'd1, 1'b0, 8'd0, 12);
    add(1'b0, 13, 1'b0, 1'b0, 4'd2, 1'b0, 8'd0, 12);
    add(1'b1, 14, 1'b0, 1'b0, 4'd2, 1'b0, 8'd0, 12);
    add(1'b0, 14, 1'b0, 1'b0, 4'd3, 1'b0, 8'd0, 12);
    add(1'b1, 15, 1'b0, 1'b0, 4'd3, 1'b0, 8'd0, 12);
    add(1'b0, 15, 1'b1, 1'b1, 4'd0, 1'b0, 8'd0, -1);
    add(1'b0, -1, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0, -1);

    repeat (2) tick();
    chk_empty("reset");
    n_p_reset16 = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      drive_idle();
      mem_write_age16 = v.wr;
      log_pop16 = v.pop;
      log_clr16 = v.clr;
      if (v.ev >= 0) begin
        mem_addr_age16 = e_idx[v.ev]; lst_inv_addr_cmd16 = e_iaddr[v.ev];
        lst_inv_port_cmd16 = e_port[v.ev]; curr_time16 = e_tm[v.ev];
      end
      tick();
      chk($sformatf("row%0d count", i), 64'(log_count16), 64'(v.cnt));
      chk($sformatf("row%0d valid", i), 64'(log_valid16), 64'(v.hk >= 0));
      chk($sformatf("row%0d overflow", i), 64'(log_overflow16), 64'(v.ovf));
      chk($sformatf("row%0d drop", i), 64'(drop_cnt16), 64'(v.drop));
      chk($sformatf("row%0d addr", i), 64'(log_addr16), (v.hk >= 0) ? 64'(e_iaddr[v.hk]) : 64'h0);
      chk($sformatf("row%0d port", i), 64'(log_port16), (v.hk >= 0) ? 64'(e_port[v.hk]) : 64'h0);
      chk($sformatf("row%0d index", i), 64'(log_index16), (v.hk >= 0) ? 64'(e_idx[v.hk]) : 64'h0);
      chk($sformatf("row%0d time", i), 64'(log_time16), (v.hk >= 0) ? 64'(e_tm[v.hk]) : 64'h0);
    end

    // invalidate-all sweep: 256-cycle write run
    drive_idle();
    for (int c = 0; c < 256; c++) begin
      mem_write_age16 = 1'b1;
      mem_addr_age16 = 8'(c);
      tick();
      if (c == 128) chk("sweep mid count", 64'(log_count16), 64'h0);
    end
    drive_idle();
    repeat (3) tick();
    chk_empty("sweep end");

    // drop count saturates at 255
    for (int p = 0; p < 265; p++) begin
      mem_write_age16 = 1'b1;
      tick();
      mem_write_age16 = 1'b0;
      tick();
    end
    tick();
    chk("sat count", 64'(log_count16), 64'h8);
    chk("sat overflow", 64'(log_overflow16), 64'h1);
    chk("sat drop", 64'(drop_cnt16), 64'hFF);

    // reset one cycle after a write pulse, with a full log
    mem_write_age16 = 1'b1;
    mem_addr_age16 = 8'h77;
    tick();
    mem_write_age16 = 1'b0;
    n_p_reset16 = 1'b0;
    #1;
    chk("async reset count", 64'(log_count16), 64'h0);
    tick();
    n_p_reset16 = 1'b1;
    repeat (4) tick();
    chk_empty("post reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
